// File: rtl/ifetch_queue.sv
// Sequential instruction prefetch queue: issues word fetches on a req/gnt/rvalid
// bus, buffers up to DEPTH {inst, pc} entries and flushes on a branch redirect.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = AW + 1;
  localparam logic [CW:0] LP_DEPTH = DEPTH[CW:0];

  logic [31:0]   r_inst_q [DEPTH];
  logic [31:0]   r_pc_q   [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, r_inflight, r_stale;
  logic          r_drop_pend;
  logic          r_req;
  logic [31:0]   r_addr, r_fetch_pc, r_resp_pc;

  logic          w_grant, w_pop, w_drop, w_push, w_launch;
  logic [31:0]   w_redirect_pc, w_launch_pc;
  logic [CW-1:0] w_count_nxt, w_inflight_nxt, w_stale_nxt;
  logic [CW:0]   w_occ_nxt;
  logic          w_drop_pend_nxt, w_req_nxt;
  logic [31:0]   w_addr_nxt, w_fetch_pc_nxt, w_resp_pc_nxt;
  logic [AW-1:0] w_wptr_nxt, w_rptr_nxt;

  // Core handshake: an entry transfers on any cycle where inst_valid_o and
  // inst_ready_i are both high; valid never depends on ready.
  assign inst_valid_o = (r_count != '0);
  assign inst_o       = r_inst_q[r_rptr];
  assign inst_pc_o    = r_pc_q[r_rptr];
  assign mem_req_o    = r_req;
  assign mem_addr_o   = r_addr;

  assign w_grant       = r_req & mem_gnt_i;
  assign w_pop         = inst_valid_o & inst_ready_i;
  assign w_drop        = mem_rvalid_i & (r_stale != '0);
  assign w_push        = mem_rvalid_i & ~w_drop & ~redirect_i;
  assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};

  always_comb begin
    w_inflight_nxt  = r_inflight + CW'(w_grant) - CW'(mem_rvalid_i);
    w_count_nxt     = r_count + CW'(w_push) - CW'(w_pop);
    w_stale_nxt     = r_stale - CW'(w_drop) + CW'(w_grant & r_drop_pend);
    w_drop_pend_nxt = r_drop_pend & ~w_grant;
    w_resp_pc_nxt   = w_push ? r_resp_pc + 32'd4 : r_resp_pc;
    w_wptr_nxt      = r_wptr + AW'(w_push);
    w_rptr_nxt      = r_rptr + AW'(w_pop);
    w_launch_pc     = r_fetch_pc;
    if (redirect_i) begin
      // Everything still owed by the bus after this edge belongs to the old path.
      w_count_nxt     = '0;
      w_stale_nxt     = w_inflight_nxt;
      w_drop_pend_nxt = r_req & ~mem_gnt_i;
      w_resp_pc_nxt   = w_redirect_pc;
      w_wptr_nxt      = '0;
      w_rptr_nxt      = '0;
      w_launch_pc     = w_redirect_pc;
    end
    w_occ_nxt      = {1'b0, w_count_nxt} + {1'b0, w_inflight_nxt};
    w_launch       = (~r_req | mem_gnt_i) & (w_occ_nxt < LP_DEPTH);
    w_req_nxt      = w_launch | (r_req & ~mem_gnt_i);
    w_addr_nxt     = w_launch ? w_launch_pc : r_addr;
    w_fetch_pc_nxt = w_launch ? w_launch_pc + 32'd4 : w_launch_pc;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_req       <= 1'b0;
      r_addr      <= RESET_PC;
      r_fetch_pc  <= RESET_PC;
      r_resp_pc   <= RESET_PC;
      r_count     <= '0;
      r_inflight  <= '0;
      r_stale     <= '0;
      r_drop_pend <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else begin
      r_req       <= w_req_nxt;
      r_addr      <= w_addr_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_resp_pc   <= w_resp_pc_nxt;
      r_count     <= w_count_nxt;
      r_inflight  <= w_inflight_nxt;
      r_stale     <= w_stale_nxt;
      r_drop_pend <= w_drop_pend_nxt;
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_q[i] <= '0;
        r_pc_q[i]   <= '0;
      end
    end else if (w_push) begin
      r_inst_q[r_wptr] <= mem_rdata_i;
      r_pc_q[r_wptr]   <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and randomized bench for ifetch_queue: an in-order memory model with
// variable latency, plus a reference of the PC stream the core should see.
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // memory model: granted addresses awaiting a response, with release cycle
  logic [31:0] exp_q[$];
  int          rdy_q[$];
  int          cyc = 0;
  int          grants, pops;
  int          gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1;
  logic        redir_req = 1'b0;
  logic [31:0] redir_pc  = '0;

  // reference: the core must see exp_pc, exp_pc+4, ... since the last restart
  logic [31:0] exp_pc, exp_fetch;
  logic        skip_one;
  logic        prev_req, prev_gnt;
  logic [31:0] prev_addr;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;
  logic [31:0] pop_pcs[$];
  int          valid_cnt, pops_before;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    rdy_q.delete();
    pop_pcs.delete();
    exp_pc    = RESET_PC;
    exp_fetch = RESET_PC;
    skip_one  = 1'b0;
    prev_req  = 1'b0;
    prev_gnt  = 1'b0;
    prev_addr = '0;
    redir_req = 1'b0;
    grants    = 0;
    pops      = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("rst_req",   32'(mem_req_o),    32'd0);
    check("rst_addr",  mem_addr_o,        RESET_PC);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst",  inst_o,            32'd0);
    check("rst_pc",    inst_pc_o,         32'd0);
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    inst_ready_i  = 1'b0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    model_clear();
  endtask

  // One bus cycle: sample at the falling edge, drive inputs for the next rising
  // edge, and advance the model as if that edge had happened.
  task automatic step();
    logic g, rv, rd;
    int   lat;
    @(negedge clk_i);
    s_req   = mem_req_o;
    s_addr  = mem_addr_o;
    s_valid = inst_valid_o;
    s_inst  = inst_o;
    s_pc    = inst_pc_o;
    if (prev_req && !prev_gnt) begin
      check("hold_req",  32'(s_req), 32'd1);
      check("hold_addr", s_addr,     prev_addr);
    end
    g  = ($urandom_range(99) < 32'(gnt_pct));
    rv = (exp_q.size() > 0) && (cyc >= rdy_q[0]);
    rd = ($urandom_range(99) < 32'(ready_pct));
    mem_gnt_i     = g;
    mem_rvalid_i  = rv;
    mem_rdata_i   = rv ? mem_word(exp_q[0]) : $urandom;
    inst_ready_i  = rd;
    redirect_i    = redir_req;
    redirect_pc_i = redir_req ? redir_pc : $urandom;
    if (rv) begin
      void'(exp_q.pop_front());
      void'(rdy_q.pop_front());
    end
    if (s_valid && rd) begin
      check("pop_pc",   s_pc,   exp_pc);
      check("pop_inst", s_inst, mem_word(exp_pc));
      pop_pcs.push_back(s_pc);
      exp_pc += 32'd4;
      pops++;
    end
    if (s_req && g) begin
      grants++;
      if (skip_one) skip_one = 1'b0;
      else begin
        check("grant_addr", s_addr, exp_fetch);
        exp_fetch += 32'd4;
      end
      lat = $urandom_range(lat_max, lat_min);
      exp_q.push_back(s_addr);
      rdy_q.push_back(cyc + lat);
      check("inflight_cap", 32'(exp_q.size() <= DEPTH), 32'd1);
    end
    if (redir_req) begin
      exp_pc    = {redir_pc[31:2], 2'b00};
      exp_fetch = {redir_pc[31:2], 2'b00};
      skip_one  = s_req && !g;
      redir_req = 1'b0;
    end
    prev_req  = s_req;
    prev_gnt  = g;
    prev_addr = s_addr;
    cyc++;
  endtask

  initial begin
    rst_n_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    inst_ready_i  = 1'b0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;

    // streaming: gnt always, 1-cycle response, core always ready
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    step();
    check("first_req",   32'(s_req),   32'd1);
    check("first_addr",  s_addr,       RESET_PC);
    check("first_valid", 32'(s_valid), 32'd0);
    step();
    valid_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_valid) valid_cnt++;
    end
    check("stream_rate", 32'(valid_cnt), 32'd12);
    check("stream_pc0",  pop_pcs[0], 32'h0);
    check("stream_pc1",  pop_pcs[1], 32'h4);
    check("stream_pc2",  pop_pcs[2], 32'h8);

    // core stalled: queue fills to DEPTH, then one pop allows one more fetch
    ready_pct = 0;
    do_reset();
    repeat (12) step();
    check("full_grants", 32'(grants),  32'(DEPTH));
    check("full_req",    32'(s_req),   32'd0);
    check("full_valid",  32'(s_valid), 32'd1);
    ready_pct = 100;
    step();
    ready_pct = 0;
    step();
    check("resume_req", 32'(s_req), 32'd1);
    step();
    check("resume_idle",   32'(s_req),  32'd0);
    check("resume_grants", 32'(grants), 32'(DEPTH + 1));

    // grant held off at 0x10 with a redirect during the stall
    ready_pct = 100;
    do_reset();
    for (int i = 0; i < 20 && grants < 4; i++) step();
    check("hold_setup", 32'(grants), 32'd4);
    gnt_pct = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin redir_req = 1'b1; redir_pc = 32'h200; end
      step();
      check("stall_req",  32'(s_req), 32'd1);
      check("stall_addr", s_addr,     32'h10);
      if (i == 2) pop_pcs.delete();
    end
    gnt_pct = 100;
    step();
    check("held_done_addr", s_addr, 32'h10);
    step();
    check("after_hold_addr", s_addr, 32'h200);
    for (int i = 0; i < 20 && pop_pcs.size() == 0; i++) step();
    check("after_hold_pop", pop_pcs[0], 32'h200);

    // two responses outstanding when redirecting to an unaligned PC
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int i = 0; i < 20 && exp_q.size() < 2; i++) step();
    check("inflight_setup", 32'(exp_q.size()), 32'd2);
    redir_req = 1'b1; redir_pc = 32'h1001;
    step();
    pop_pcs.delete();
    step();
    check("redir_req",  32'(s_req), 32'd1);
    check("redir_addr", s_addr,     32'h1000);
    for (int i = 0; i < 20 && pop_pcs.size() == 0; i++) step();
    check("redir_pop", pop_pcs[0], 32'h1000);

    // address wrap at the top of the space
    lat_min = 1; lat_max = 2;
    redir_req = 1'b1; redir_pc = 32'hFFFF_FFF8;
    step();
    pop_pcs.delete();
    for (int i = 0; i < 30 && pop_pcs.size() < 3; i++) step();
    check("wrap_pc0", pop_pcs[0], 32'hFFFF_FFF8);
    check("wrap_pc1", pop_pcs[1], 32'hFFFF_FFFC);
    check("wrap_pc2", pop_pcs[2], 32'h0000_0000);

    // reset in the middle of a burst, then restart
    repeat (3) step();
    do_reset();
    step();
    check("restart_req",  32'(s_req), 32'd1);
    check("restart_addr", s_addr,     RESET_PC);

    // randomized traffic with random redirects, some back-to-back
    gnt_pct = 70; ready_pct = 70; lat_min = 1; lat_max = 4;
    pops_before = pops;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(24) == 0 || (i % 300) == 151 || (i % 300) == 152) begin
        redir_req = 1'b1;
        redir_pc  = $urandom;
      end
      step();
    end
    gnt_pct = 100; ready_pct = 100;
    repeat (30) step();
    check("random_progress", 32'(pops - pops_before >= 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
